// File: rtl/test_port_snoop.sv
// ---------------------------------------------------------------------------
// test_port_snoop
//
// Watches the D-side bus for processor stores to the test port word address.
// It then streams the captured words, in order, to the result checker. A
// store held on the bus across D-cache stall cycles is captured once, on its
// first unstalled cycle. Capture is armed by BEGIN_SYM, which is not itself
// forwarded. Capture ends with END_SYM, which is forwarded and tagged as the
// last word. Words are buffered in a FIFO so the checker can apply
// back-pressure. Captures that find the FIFO full are dropped and counted.
//
// Build option:
//   BYTE_SWAP_EN  when defined, store data is byte-reversed before the marker
//                 compares and before being written into the FIFO.
//
// Parameters:
//   PORT_ADDR   word address of the test port
//   BEGIN_SYM   arming marker
//   END_SYM     terminating marker
//   DEPTH       FIFO entries (power of two, >= 2)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   bus_addr    D-side word address
//   bus_wdata   D-side write data
//   bus_wen     D-side write enable
//   bus_stall   D-cache stall; a write is not final while high
//   out_valid   FIFO head valid
//   out_data    FIFO head word, 0 when empty
//   out_last    head word is END_SYM, 0 when empty
//   out_ready   checker accepts the head this cycle
//   armed       BEGIN_SYM seen, END_SYM not yet captured
//   done        END_SYM captured (sticky until reset)
//   overflow    sticky, a capture was dropped on a full FIFO
//   drop_cnt    dropped captures, saturating
//   fifo_count  occupied FIFO entries
// ---------------------------------------------------------------------------
module test_port_snoop #(
   parameter logic [29:0] PORT_ADDR = 30'h3FF,
   parameter logic [31:0] BEGIN_SYM = 32'h00000168,
   parameter logic [31:0] END_SYM   = 32'hFFFFFD5D,
   parameter int unsigned DEPTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [29:0]              bus_addr,
   input  logic [31:0]              bus_wdata,
   input  logic                     bus_wen,
   input  logic                     bus_stall,
   output logic                     out_valid,
   output logic [31:0]              out_data,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic                     armed,
   output logic                     done,
   output logic                     overflow,
   output logic [7:0]               drop_cnt,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_DONE
   } state_t;

   state_t         state;
   logic           hold;
   logic [31:0]    w;
   logic           wr_event;
   logic           is_begin;
   logic           is_end;

   logic [32:0]    mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           empty;
   logic           full;
   logic           pop;
   logic           push_req;
   logic           push_ok;
   logic           drop;

`ifdef BYTE_SWAP_EN
   assign w = {bus_wdata[7:0], bus_wdata[15:8], bus_wdata[23:16], bus_wdata[31:24]};
`else
   assign w = bus_wdata;
`endif

   // hold blocks re-capture of a store that lingers on the bus after its
   // final cycle; it only re-arms once bus_wen drops.
   assign wr_event = bus_wen && (bus_addr == PORT_ADDR) && !bus_stall && !hold;
   assign is_begin = (w == BEGIN_SYM);
   assign is_end   = (w == END_SYM);

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign pop      = !empty && out_ready;
   assign push_req = wr_event && (state == ST_ARMED);
   // A full FIFO still accepts a push when the head leaves in the same cycle;
   // the freed slot is the one the write pointer already points at.
   assign push_ok  = push_req && (!full || pop);
   assign drop     = push_req && !push_ok;

   // Control: stall filter, capture FSM and drop bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold     <= 1'b0;
         state    <= ST_IDLE;
         armed    <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (wr_event) begin
            hold <= 1'b1;
         end else if (!bus_wen) begin
            hold <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (wr_event && is_begin) begin
                  state <= ST_ARMED;
                  armed <= 1'b1;
               end
            end
            ST_ARMED: begin
               // END_SYM terminates capture even if its own push was dropped.
               if (wr_event && is_end) begin
                  state <= ST_DONE;
                  armed <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
               armed <= 1'b0;
               done  <= 1'b0;
            end
         endcase

         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   // Result FIFO: entry = {last, word}.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {is_end, w};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign out_valid  = !empty;
   assign out_data   = empty ? '0 : mem[rd_ptr][31:0];
   assign out_last   = !empty && mem[rd_ptr][32];
   assign fifo_count = count;

endmodule

// File: tb/tb_test_port_snoop.sv
// ---------------------------------------------------------------------------
// tb_test_port_snoop
//
// Directed bench for test_port_snoop with DEPTH=8. Test words are given as
// the value the snooper should see after the optional byte swap. The bench
// encodes them onto the bus with enc(), which is a byte-reversal when
// BYTE_SWAP_EN is defined and the identity otherwise.
// ---------------------------------------------------------------------------
module tb_test_port_snoop;

   localparam logic [29:0] PORT  = 30'h3FF;
   localparam logic [31:0] BEGW  = 32'h00000168;
   localparam logic [31:0] ENDW  = 32'hFFFFFD5D;

   logic        clk;
   logic        rst;
   logic [29:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_wen;
   logic        bus_stall;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready;
   logic        armed;
   logic        done;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic [3:0]  fifo_count;

   int unsigned tests;
   int unsigned errors;

   test_port_snoop #(
      .PORT_ADDR (PORT),
      .BEGIN_SYM (BEGW),
      .END_SYM   (ENDW),
      .DEPTH     (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wen    (bus_wen),
      .bus_stall  (bus_stall),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .armed      (armed),
      .done       (done),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .fifo_count (fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] enc(input logic [31:0] v);
`ifdef BYTE_SWAP_EN
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle store followed by one idle cycle so hold re-arms.
   task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_wen   = 1'b1;
      bus_stall = 1'b0;
      tick();
      bus_wen   = 1'b0;
      tick();
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"},  out_data,       32'd0);
      check({tag, "_last"},  32'(out_last),  32'd0);
      check({tag, "_armed"}, 32'(armed),     32'd0);
      check({tag, "_done"},  32'(done),      32'd0);
      check({tag, "_ovf"},   32'(overflow),  32'd0);
      check({tag, "_drops"}, 32'(drop_cnt),  32'd0);
      check({tag, "_count"}, 32'(fifo_count), 32'd0);
   endtask

   initial begin
      tests     = 0;
      errors    = 0;
      rst       = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      bus_wen   = 1'b0;
      bus_stall = 1'b0;
      out_ready = 1'b0;

      #1;
      check_reset_outputs("rst0");
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Pre-arm traffic: non-marker to the port, marker to the wrong address.
      bus_write(PORT, enc(32'h00000005));
      bus_write(30'h3FE, enc(BEGW));
      check("prearm_count", 32'(fifo_count), 32'd0);
      check("prearm_armed", 32'(armed), 32'd0);
      check("prearm_drops", 32'(drop_cnt), 32'd0);

      // Arm; the marker itself is not queued.
`ifdef BYTE_SWAP_EN
      bus_write(PORT, 32'h68010000);
`else
      bus_write(PORT, BEGW);
`endif
      check("arm_armed", 32'(armed), 32'd1);
      check("arm_count", 32'(fifo_count), 32'd0);

`ifdef BYTE_SWAP_EN
      bus_write(PORT, 32'h01000000);
`else
      bus_write(PORT, 32'h00000001);
`endif
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_data",  out_data, 32'h00000001);
      check("first_count", 32'(fifo_count), 32'd1);
      pop_one();
      check("pop_empty_valid", 32'(out_valid), 32'd0);
      check("pop_empty_data",  out_data, 32'd0);

      // Ready while empty does nothing.
      pop_one();
      check("ready_empty_count", 32'(fifo_count), 32'd0);

      // Stalled store: 5 stall cycles, then 2 unstalled; data changes after
      // the first unstalled edge so a late capture would be visible.
      bus_addr  = PORT;
      bus_wdata = enc(32'hA5A50001);
      bus_wen   = 1'b1;
      bus_stall = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("stall_count", 32'(fifo_count), 32'd0);
      bus_stall = 1'b0;
      tick();
      check("unstall_count", 32'(fifo_count), 32'd1);
      bus_wdata = enc(32'hA5A50002);
      tick();
      check("unstall2_count", 32'(fifo_count), 32'd1);
      bus_wen = 1'b0;
      tick();
      check("stall_data", out_data, 32'hA5A50001);
      pop_one();

      // Overflow: 10 writes into 8 entries with no draining.
      for (int i = 0; i < 10; i++) bus_write(PORT, enc(32'h00000100 + 32'(i)));
      check("ovf_count", 32'(fifo_count), 32'd8);
      check("ovf_flag",  32'(overflow), 32'd1);
      check("ovf_drops", 32'(drop_cnt), 32'd2);
      check("ovf_head",  out_data, 32'h00000100);

      // Full FIFO, pop and push in the same cycle.
      out_ready = 1'b1;
      bus_addr  = PORT;
      bus_wdata = enc(32'h00002222);
      bus_wen   = 1'b1;
      tick();
      out_ready = 1'b0;
      bus_wen   = 1'b0;
      tick();
      check("fullpp_count", 32'(fifo_count), 32'd8);
      check("fullpp_drops", 32'(drop_cnt), 32'd2);

      for (int i = 1; i < 8; i++) begin
         check("drain_data", out_data, 32'h00000100 + 32'(i));
         check("drain_last", 32'(out_last), 32'd0);
         pop_one();
      end
      check("tail_data", out_data, 32'h00002222);
      pop_one();
      check("drained_count", 32'(fifo_count), 32'd0);

      // BEGIN_SYM while armed is ordinary data.
      bus_write(PORT, enc(BEGW));
      check("begin_as_data", out_data, BEGW);
      pop_one();

      // Terminate.
      bus_write(PORT, enc(ENDW));
      check("end_done",  32'(done), 32'd1);
      check("end_armed", 32'(armed), 32'd0);
      check("end_data",  out_data, ENDW);
      check("end_last",  32'(out_last), 32'd1);
      bus_write(PORT, enc(32'h00000005));
      check("post_done_count", 32'(fifo_count), 32'd1);
      check("post_done_data",  out_data, ENDW);

      // Asynchronous reset away from the clock edge.
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("rst1");
      tick();
      rst = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/test_port_snoop.md
# test_port_snoop

Captures processor stores to the test port address on the D-side bus and streams them, in order, to the result checker. Sits between the CPU/D-cache bus and the checker. Filters repeated stalled writes, detects the begin/end markers, optionally byte-swaps little-endian words, and buffers results in a FIFO so the checker can apply back-pressure.

## Interface
- PORT_ADDR, 30'h3FF: word address of the test port.
- BEGIN_SYM, 32'h00000168: arming marker, compared after optional swap.
- END_SYM, 32'hFFFFFD5D: terminating marker, compared after optional swap.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- bus_addr  in  30  D-side word address.
- bus_wdata  in  32  D-side write data.
- bus_wen  in  1  D-side write enable.
- bus_stall  in  1  D-cache stall; a write is not final while high.
- out_valid  out  1  FIFO head valid.
- out_data  out  32  FIFO head word; 0 when empty.
- out_last  out  1  head word is END_SYM; 0 when empty.
- out_ready  in  1  checker accepts head this cycle.
- armed  out  1  BEGIN_SYM seen, END_SYM not yet captured.
- done  out  1  END_SYM captured (sticky).
- overflow  out  1  sticky; a capture was dropped because FIFO full.
- drop_cnt  out  8  dropped captures, saturates at 255.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Write event: bus_wen=1, bus_addr==PORT_ADDR, bus_stall=0, hold=0. On event, hold<=1; hold clears on the first cycle bus_wen=0. Exactly one event per continuous bus_wen assertion regardless of stall cycles or address.
- w = swapped or raw bus_wdata (see Configuration).
- FSM IDLE -> ARMED -> DONE.
  - IDLE: event with w==BEGIN_SYM -> ARMED; marker not pushed. Other events ignored, not counted.
  - ARMED: every event pushes {w, last=(w==END_SYM)}. Event with w==END_SYM -> DONE whether or not push succeeded. BEGIN_SYM seen in ARMED is ordinary data.
  - DONE: events ignored; FIFO keeps draining. Leaves only by reset.
- Push when FIFO not full, or full with pop same cycle (slot reused). Otherwise drop: overflow<=1, drop_cnt+=1 saturating.
- Pop when out_valid && out_ready. out_ready while empty has no effect.
- armed = (state==ARMED); done = (state==DONE).

## Timing
- Reset: state IDLE, hold 0, FIFO empty, out_valid 0, out_data 0, out_last 0, armed 0, done 0, overflow 0, drop_cnt 0, fifo_count 0.
- Event at edge N -> out_valid=1 with that word after edge N (1-cycle latency) if FIFO was empty.
- armed rises the cycle after BEGIN event; done rises the cycle after END event.
- Simultaneous push/pop: fifo_count unchanged; order preserved.
- Pointers wrap modulo DEPTH; fifo_count distinguishes full (DEPTH) from empty (0).
- Reset mid-operation clears FIFO contents and all flags immediately (async).
- bus_stall high with bus_wen high: no event; hold stays 0 until stall releases, so the write captures on the first unstalled cycle.

## Configuration
- BYTE_SWAP_EN defined: w = {d[7:0],d[15:8],d[23:16],d[31:24]}; marker compares and FIFO data use swapped value.
- Undefined: w = bus_wdata unchanged everywhere.

## Test plan
- BYTE_SWAP_EN on: write bus_wdata=32'h68010000 to 3FF -> armed=1 next cycle, fifo_count=0; then write 32'h01000000 -> out_data=32'h00000001, out_valid=1.
- Write to 3FF held bus_wen=1 with bus_stall=1 for 5 cycles then stall=0 for 2 cycles -> exactly one entry, captured on first unstalled cycle.
- Armed, out_ready=0, 10 distinct writes with DEPTH=8 -> fifo_count=8, overflow=1, drop_cnt=2; drain -> first 8 words in order.
- Full FIFO, out_ready=1 same cycle as new write -> fifo_count stays 8, drop_cnt unchanged, new word at tail.
- Write END_SYM while armed -> done=1, head with out_last=1; later write 32'h5 ignored, fifo_count unchanged.
- Writes to addr 3FE and pre-arm writes to 3FF -> no entries, drop_cnt=0; assert rst=0 mid-stream -> all outputs return to reset values.
